// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the sequential shift/rotate unit.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SHR  = 3'b000,
        OP_SHRA = 3'b001,
        OP_SHL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

    // Bits to move this clock: min(step, remaining).
    function automatic int unsigned step_amt(input int unsigned step, input int unsigned remaining);
        return (remaining < step) ? remaining : step;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP bits, with the last bit moved out.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned AMT_W = $clog2(STEP + 1)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] word,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] shifted,
    output logic             out_bit
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] hi_idx;
    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] rot_l;
    logic             nonzero;

    always_comb begin
        nonzero = (amt != '0);
        lo_idx  = IDX_W'(amt) - IDX_W'(1);
        hi_idx  = IDX_W'(WIDTH - 32'(amt));
        // amt never reaches WIDTH, so the complementary shift stays in range; amt=0 yields word.
        rot_r   = (word >> amt) | (word << (WIDTH - 32'(amt)));
        rot_l   = (word << amt) | (word >> (WIDTH - 32'(amt)));

        shifted = word;
        out_bit = 1'b0;
        case (op)
            OP_SHR: begin
                shifted = word >> amt;
                out_bit = nonzero ? word[lo_idx] : 1'b0;
            end
            OP_SHRA: begin
                shifted = $signed(word) >>> amt;
                out_bit = nonzero ? word[lo_idx] : 1'b0;
            end
            OP_SHL: begin
                shifted = word << amt;
                out_bit = nonzero ? word[hi_idx] : 1'b0;
            end
            OP_ROR: begin
                shifted = rot_r;
                out_bit = nonzero ? rot_r[WIDTH-1] : 1'b0;
            end
            OP_ROL: begin
                shifted = rot_l;
                out_bit = nonzero ? rot_l[0] : 1'b0;
            end
            default: begin
                shifted = word;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: start/done handshake, STEP bits per clock, result held for Zlow/Zhigh.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] count_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             illegal_op
);

    localparam int unsigned AMT_W = $clog2(STEP + 1);

    state_e           state;
    state_e           state_n;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] remaining;

    logic [CNT_W-1:0] n_in;
    logic             go_shift;
    logic [AMT_W-1:0] amt;
    logic             last_step;
    logic [WIDTH-1:0] shifted;
    logic             out_bit;
    logic             unused_count_hi;

    assign unused_count_hi = ^count_in[WIDTH-1:CNT_W];

    assign n_in      = count_in[CNT_W-1:0];
    assign go_shift  = (n_in != '0) && op_is_legal(op);
    assign amt       = AMT_W'(step_amt(STEP, 32'(remaining)));
    assign last_step = (remaining == CNT_W'(amt));

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .op      (op_q),
        .word    (work),
        .amt     (amt),
        .shifted (shifted),
        .out_bit (out_bit)
    );

    always_ff @(posedge clock) begin
        if (clear) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = go_shift ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (last_step) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            op_q       <= '0;
            work       <= '0;
            remaining  <= '0;
            result     <= '0;
            carry_out  <= 1'b0;
            zero       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        work      <= operand;
                        remaining <= n_in;
                        carry_out <= 1'b0;
                        // Zero-count and illegal requests skip SHIFT, so publish straight away.
                        if (!go_shift) begin
                            result     <= operand;
                            zero       <= (operand == '0);
                            illegal_op <= !op_is_legal(op);
                        end
                    end
                end
                ST_SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - CNT_W'(amt);
                    carry_out <= out_bit;
                    if (last_step) begin
                        result     <= shifted;
                        zero       <= (shifted == '0);
                        illegal_op <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised multi-cycle shift/rotate unit for the single-bus datapath. Replaces the fixed single-cycle SHRA path feeding Zlow.
- Supports SHR, SHRA, SHL, ROR and ROL at configurable WIDTH, with STEP bits processed per clock.
- Start/done handshake with the control unit; the result is held stable for the Zlow/Zhigh transfer cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (power of 2, >= 8)
- STEP, 1, maximum bits shifted per clock (power of 2, 1..WIDTH/2)
- CNT_W, $clog2(WIDTH), width of the effective shift count

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only while busy=0
- op  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 illegal
- operand  in  WIDTH  value to shift (Y register side)
- count_in  in  WIDTH  shift amount from bus; only [CNT_W-1:0] is used
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  shifted value; held until next accepted start or clear
- carry_out  out  1  last bit shifted/rotated out; 0 if count is 0
- zero  out  1  result == 0; updated with result
- illegal_op  out  1  set with done when op is 101-111

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - clock/clear: one clock; reset is synchronous and active-high.
  - clear=1 at an edge forces: state=IDLE, busy=0, done=0, result=0, carry_out=0, zero=0, illegal_op=0.
  - clear has priority over everything, including mid-operation; the in-flight operation is discarded with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: latch op, operand into the work register, n = count_in[CNT_W-1:0] into remaining. Clear carry_out.
  - Next state is SHIFT if n!=0 and op is legal; otherwise DONE.
- SHIFT, each edge:
  - s = min(STEP, remaining); work is shifted by s per op; remaining -= s.
  - carry_out = the last bit leaving the word this step (SHR/SHRA: work[s-1]; SHL: work[WIDTH-s]; ROR: new msb; ROL: new lsb).
  - When remaining reaches 0, go to DONE.
- DONE:
  - done=1 for exactly one cycle; result=work; zero=(work==0); illegal_op reflects the latched op.
  - Next edge returns to IDLE.
- Latency:
  - done is high ceil(n/STEP)+1 cycles after the accepting edge is counted inclusive. The DONE state is entered on edge k+ceil(n/STEP), where k is the accept edge.
  - n=0 gives done in the cycle immediately after accept.
- Shift semantics:
  - SHR fills with 0.
  - SHRA replicates operand msb.
  - SHL fills with 0.
  - Rotates are modulo WIDTH; a count is always < WIDTH by truncation.
- Boundary cases:
  - Illegal op: no shifting, result=operand, carry_out=0, illegal_op=1 alongside done.
  - start while busy=1, including in DONE, is ignored. There is no queueing.
  - result, zero, carry_out and illegal_op keep their values in IDLE until the next accept. result updates only on entering DONE.
  - Changes to operand or count_in after accept have no effect.

Decomposition:
- shift_pkg holds:
  - op encodings: OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL
  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE
  - a helper for min(STEP, remaining)
- Sub-module shift_step: combinational, shifts a WIDTH word by amt (0..STEP) per op and returns the shifted word and the out-bit. Instantiated once; the FSM/counters live in seq_shift_unit.

Test Plan:
- WIDTH=32, STEP=1, SHRA, operand 0xF0000012, count 0x4 -> done 5 cycles after the accept edge (counted inclusive); result 0xFF000001, carry_out 0, zero 0, busy high for 5 cycles.
- SHR and SHL on 0xF0000012, count 4 -> SHR gives 0x0F000001, carry 0; SHL gives 0x00000120, carry 1.
- ROR 0x00000018 count 4 -> 0x80000001, carry_out 1. ROL 0x80000001 count 36 (low bits 4) -> 0x00000018, carry_out 0.
- STEP=4 instance, SHR 0xFFFFFFFF count 6 -> exactly 2 SHIFT cycles (4 then 2); result 0x03FFFFFF, carry_out 1. Count 0 -> done next cycle, result=operand, carry_out 0.
- Pulse start again mid-SHIFT with different operand -> ignored; first result is unchanged. clear asserted during SHIFT -> next cycle busy 0, result 0, and no done pulse ever follows.
- op=110, operand 0x00000000 -> done one cycle after accept; illegal_op 1, result 0, zero 1.
